pair_unpack: RTL and testbench

Receive-side counterpart of the bit-pair packer. Accepts a stream of 2-bit packed symbols over a valid/ready handshake and undoes the selectable field ordering. In normal order the symbol is `{d, c}`; in swapped order it is `{c, d}`. It collects DEPTH symbols into one frame and presents the recovered `c` and `d` vectors, plus the inverted `x = ~d` vector, to a downstream consumer. It sits between the packed-symbol source and the coverage diagnostic logic that checks the recovered fields.

---
 rtl/pair_unpack_if.sv | 41 ++++
 rtl/pair_unpack.sv | 135 +++++++++++++
 tb/tb_pair_unpack.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pair_unpack_if.sv
// pair_unpack_if
// Bundles the symbol-input and frame-output handshakes of pair_unpack.
//
// Signals:
//   in_valid / in_ready  - symbol handshake (source -> unpacker)
//   in_data [1:0]        - packed 2-bit symbol
//   in_swap              - field order of in_data: 0 = {d,c}, 1 = {c,d}
//   out_valid / out_ready- frame handshake (unpacker -> consumer)
//   out_c / out_d        - recovered c and d vectors, symbol k in bit k
//   out_x                - ~out_d
//   out_err              - in_swap changed inside the presented frame
//
// Modports:
//   slave  - the unpacker's view
//   master - the view of whatever drives the unpacker (source + consumer)
interface pair_unpack_if #(
  parameter int DEPTH = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_data;
  logic             in_swap;
  logic             out_valid;
  logic             out_ready;
  logic [DEPTH-1:0] out_c;
  logic [DEPTH-1:0] out_d;
  logic [DEPTH-1:0] out_x;
  logic             out_err;

  modport slave (
    input  in_valid, in_data, in_swap, out_ready,
    output in_ready, out_valid, out_c, out_d, out_x, out_err
  );

  modport master (
    output in_valid, in_data, in_swap, out_ready,
    input  in_ready, out_valid, out_c, out_d, out_x, out_err
  );

endinterface

// File: rtl/pair_unpack.sv
// pair_unpack
// Receive-side counterpart of the bit-pair packer. Collects DEPTH packed
// 2-bit symbols into one frame, undoing the selectable field order, and
// presents the recovered c and d vectors (plus x = ~d) downstream.
//
// Ports:
//   clock - rising-edge clock
//   reset - synchronous, active-high; discards any partial frame and
//           clears the presented outputs
//   bus   - pair_unpack_if.slave carrying both handshakes (see interface)
//
// Parameters:
//   DEPTH - symbols per frame, 2..16
module pair_unpack #(
  parameter int DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset,
  pair_unpack_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             swap_q;
  logic             err_acc;
  logic [DEPTH-1:0] c_shadow;
  logic [DEPTH-1:0] d_shadow;
  logic [DEPTH-1:0] c_q;
  logic [DEPTH-1:0] d_q;
  logic             err_q;

  logic             can_accept;
  logic             beat;
  logic             dec_swap;
  logic             dec_c;
  logic             dec_d;
  logic             swap_diff;
  logic [IDX_W-1:0] idx;
  logic [DEPTH-1:0] c_merged;
  logic [DEPTH-1:0] d_merged;

  // Handshake status depends on the state register only, so neither ready
  // nor valid ever forms a combinational path from the opposite side.
  assign can_accept    = (state != FULL);
  assign bus.in_ready  = can_accept;
  assign bus.out_valid = (state == FULL);
  assign bus.out_c     = c_q;
  assign bus.out_d     = d_q;
  assign bus.out_x     = ~d_q;
  assign bus.out_err   = err_q;

  // Symbol decode. Beat 0 decodes with the live in_swap; every later beat
  // uses the order latched on beat 0, so a mid-frame change of in_swap only
  // raises the error flag and never alters the recovered bits.
  always_comb begin
    beat      = bus.in_valid && can_accept;
    dec_swap  = (state == IDLE) ? bus.in_swap : swap_q;
    dec_c     = dec_swap ? bus.in_data[1] : bus.in_data[0];
    dec_d     = dec_swap ? bus.in_data[0] : bus.in_data[1];
    swap_diff = (state == FILL) && (bus.in_swap != swap_q);
    idx       = (state == IDLE) ? '0 : cnt[IDX_W-1:0];
    c_merged  = c_shadow;
    d_merged  = d_shadow;
    c_merged[idx] = dec_c;
    d_merged[idx] = dec_d;
  end

  // Frame FSM. Partial frames live in the shadow registers; the presented
  // output registers are loaded only on the beat that completes a frame,
  // so the consumer never sees half-built data and the last frame stays
  // visible until the next one completes.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      swap_q   <= 1'b0;
      err_acc  <= 1'b0;
      c_shadow <= '0;
      d_shadow <= '0;
      c_q      <= '0;
      d_q      <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (beat) begin
            c_shadow <= DEPTH'(dec_c);
            d_shadow <= DEPTH'(dec_d);
            swap_q   <= bus.in_swap;
            err_acc  <= 1'b0;
            cnt      <= CNT_W'(1);
            state    <= FILL;
          end
        end
        FILL: begin
          if (beat) begin
            c_shadow <= c_merged;
            d_shadow <= d_merged;
            err_acc  <= err_acc | swap_diff;
            if (cnt == LAST_CNT) begin
              c_q   <= c_merged;
              d_q   <= d_merged;
              err_q <= err_acc | swap_diff;
              cnt   <= '0;
              state <= FULL;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        FULL: begin
          // No bypass back into FILL: the next frame's first beat can only
          // land on the edge after this handshake.
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pair_unpack.sv
// tb_pair_unpack
// Self-checking bench for pair_unpack (DEPTH = 4). A table of frame
// records with hand-computed c/d/x/err results is applied in a loop,
// followed by hand-written back-pressure and reset-mid-frame sequences.
module tb_pair_unpack;

  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  pair_unpack_if #(.DEPTH(DEPTH)) bus ();

  pair_unpack #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_fail = 0;

  // One frame: beat k uses data[2k+1:2k] and swap[k]; gap idle cycles are
  // inserted before every beat except the first.
  typedef struct {
    string      name;
    logic [7:0] data;
    logic [3:0] swap;
    int         gap;
    logic [3:0] exp_c;
    logic [3:0] exp_d;
    logic [3:0] exp_x;
    logic       exp_err;
  } vec_t;

  vec_t vecs [7];

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drive one whole frame, then check the presented result one cycle after
  // the final beat.
  task automatic apply_stimulus(input vec_t v);
    int w;
    for (int k = 0; k < DEPTH; k++) begin
      if (k > 0) begin
        for (int g = 0; g < v.gap; g++) begin
          bus.in_valid = 1'b0;
          bus.in_data  = 2'($urandom);
          bus.in_swap  = 1'($urandom);
          step();
        end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = v.data[2*k +: 2];
      bus.in_swap  = v.swap[k];
      w = 0;
      while (!bus.in_ready && w < 20) begin
        step();
        w++;
      end
      if (!bus.in_ready) begin
        check_output({v.name, " in_ready timeout"}, 32'd0, 32'd1);
      end
      check_output({v.name, " out_valid mid-frame"}, 32'(bus.out_valid), 32'd0);
      step();
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 2'($urandom);
    bus.in_swap  = 1'($urandom);
    check_output({v.name, " out_valid"}, 32'(bus.out_valid), 32'd1);
    check_output({v.name, " in_ready full"}, 32'(bus.in_ready), 32'd0);
    check_output({v.name, " out_c"}, 32'(bus.out_c), 32'(v.exp_c));
    check_output({v.name, " out_d"}, 32'(bus.out_d), 32'(v.exp_d));
    check_output({v.name, " out_x"}, 32'(bus.out_x), 32'(v.exp_x));
    check_output({v.name, " out_err"}, 32'(bus.out_err), 32'(v.exp_err));
  endtask

  // Accept the presented frame; valid must drop and ready return next cycle.
  task automatic release_frame(input string name);
    bus.out_ready = 1'b1;
    step();
    check_output({name, " out_valid after handshake"}, 32'(bus.out_valid), 32'd0);
    check_output({name, " in_ready after handshake"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    vec_t bp_vec;

    vecs[0] = '{"normal",   8'b00_11_01_10, 4'b0000, 0, 4'b0110, 4'b0101, 4'b1010, 1'b0};
    vecs[1] = '{"swapped",  8'b00_11_01_10, 4'b1111, 0, 4'b0101, 4'b0110, 4'b1001, 1'b0};
    vecs[2] = '{"midswap",  8'b00_11_01_10, 4'b0100, 0, 4'b0110, 4'b0101, 4'b1010, 1'b1};
    vecs[3] = '{"clean",    8'b00_11_01_10, 4'b0000, 0, 4'b0110, 4'b0101, 4'b1010, 1'b0};
    vecs[4] = '{"gaps",     8'b00_11_01_10, 4'b0000, 2, 4'b0110, 4'b0101, 4'b1010, 1'b0};
    vecs[5] = '{"pattern2", 8'b01_00_11_11, 4'b0000, 1, 4'b1011, 4'b0011, 4'b1100, 1'b0};
    vecs[6] = '{"swap_err", 8'b01_00_11_11, 4'b1101, 0, 4'b0011, 4'b1011, 4'b0100, 1'b1};
    bp_vec  = '{"after_bp", 8'b10_01_00_11, 4'b0000, 0, 4'b0101, 4'b1001, 4'b0110, 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_data   = 2'b00;
    bus.in_swap   = 1'b0;
    bus.out_ready = 1'b1;
    reset         = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset values held over idle cycles; out_ready high outside FULL.
    for (int i = 0; i < 3; i++) begin
      check_output("reset out_valid", 32'(bus.out_valid), 32'd0);
      check_output("reset in_ready", 32'(bus.in_ready), 32'd1);
      check_output("reset out_c", 32'(bus.out_c), 32'd0);
      check_output("reset out_d", 32'(bus.out_d), 32'd0);
      check_output("reset out_x", 32'(bus.out_x), 32'hF);
      check_output("reset out_err", 32'(bus.out_err), 32'd0);
      step();
    end

    // Table-driven frames with the consumer always ready.
    for (int i = 0; i < 7; i++) begin
      bus.out_ready = 1'b1;
      apply_stimulus(vecs[i]);
      release_frame(vecs[i].name);
    end

    // Back-pressure: consumer stalls while the source offers a new symbol.
    bus.out_ready = 1'b0;
    apply_stimulus(vecs[0]);
    bus.in_valid = 1'b1;
    bus.in_data  = 2'b11;
    bus.in_swap  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_output("stall in_ready", 32'(bus.in_ready), 32'd0);
      check_output("stall out_valid", 32'(bus.out_valid), 32'd1);
      check_output("stall out_c", 32'(bus.out_c), 32'h6);
      check_output("stall out_d", 32'(bus.out_d), 32'h5);
      check_output("stall out_err", 32'(bus.out_err), 32'd0);
    end
    release_frame("stall");
    apply_stimulus(bp_vec);
    release_frame(bp_vec.name);

    // Reset after two beats of a frame.
    bus.in_valid = 1'b1;
    bus.in_data  = 2'b11;
    bus.in_swap  = 1'b1;
    step();
    bus.in_data  = 2'b10;
    step();
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    step();
    reset        = 1'b0;
    check_output("midreset out_valid", 32'(bus.out_valid), 32'd0);
    check_output("midreset in_ready", 32'(bus.in_ready), 32'd1);
    check_output("midreset out_c", 32'(bus.out_c), 32'd0);
    check_output("midreset out_d", 32'(bus.out_d), 32'd0);
    check_output("midreset out_x", 32'(bus.out_x), 32'hF);
    check_output("midreset out_err", 32'(bus.out_err), 32'd0);
    apply_stimulus(vecs[0]);
    release_frame("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
